// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one registered 5-bit ALU among NUM_REQ requesters. The controller
//   picks a requester round-robin and registers its opcode and operands onto
//   the ALU inputs. It waits ALU_LAT cycles for the ALU pipeline, captures the
//   result, and returns it on a valid/ready response channel tagged with the
//   requester id. It handles one operation at a time.
//
// Ports
//   clk, rst                          clock (rising edge), async active-high reset
//   req_valid / req_ready             per-requester handshake (ready is one-hot or zero)
//   req_opcode / req_in1 / req_in2    packed per-requester payload (3/5/5 bits each)
//   rsp_valid / rsp_ready             response handshake
//   rsp_id / rsp_result               owner index and captured 6-bit ALU result
//   alu_opcode / alu_in1 / alu_in2    registered drive to the ALU
//   alu_result                        ALU output
//   busy                              high whenever an operation is in flight
module alu_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_opcode,
  input  logic [5*NUM_REQ-1:0] req_in1,
  input  logic [5*NUM_REQ-1:0] req_in2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [5:0]           rsp_result,
  output logic [2:0]           alu_opcode,
  output logic [4:0]           alu_in1,
  output logic [4:0]           alu_in2,
  input  logic [5:0]           alu_result,
  output logic                 busy
);

  localparam int unsigned NREQ_U = NUM_REQ;
  localparam int          CNT_W  = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        in1_q, in1_d;
  logic [4:0]        in2_q, in2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [5:0]        rsp_result_q, rsp_result_d;

  // Round-robin winner search starting at rr_ptr.
  logic              found;
  logic [ID_W-1:0]   win;
  int unsigned       win_n;
  int unsigned       idx_n;

  always_comb begin
    found = 1'b0;
    win   = '0;
    win_n = 0;
    idx_n = 0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx_n = (32'(rr_ptr_q) + k) % NREQ_U;
      if (!found && req_valid[ID_W'(idx_n)]) begin
        found = 1'b1;
        win   = ID_W'(idx_n);
        win_n = idx_n;
      end
    end
  end

  // Grant is combinational in IDLE; suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && found) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          op_d     = req_opcode[3*win_n +: 3];
          in1_d    = req_in1[5*win_n +: 5];
          in2_d    = req_in2[5*win_n +: 5];
          cnt_d    = CNT_W'(ALU_LAT);
          rr_ptr_d = ID_W'((win_n + 1) % NREQ_U);
          id_d     = win;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // Response id/result are kept after acceptance; only valid drops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign alu_opcode = op_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU drives alu_result, a
// transaction-level model predicts grants and responses, and a monitor
// compares every presented response against the scoreboard queue.
module tb_alu_share_ctrl;
  localparam int N    = 4;
  localparam int LAT  = 1;
  localparam int LAT2 = 2;
  localparam int IDW  = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT (ALU_LAT = 1)
  logic [N-1:0]   req_valid, req_ready;
  logic [3*N-1:0] req_opcode;
  logic [5*N-1:0] req_in1, req_in2;
  logic           rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [5:0]     rsp_result, alu_result;
  logic [2:0]     alu_opcode;
  logic [4:0]     alu_in1, alu_in2;
  logic           busy;

  // Second DUT (ALU_LAT = 2)
  logic [N-1:0]   req2_valid, req2_ready;
  logic [3*N-1:0] req2_opcode;
  logic [5*N-1:0] req2_in1, req2_in2;
  logic           rsp2_valid, rsp2_ready;
  logic [IDW-1:0] rsp2_id;
  logic [5:0]     rsp2_result, alu2_result;
  logic [2:0]     alu2_opcode;
  logic [4:0]     alu2_in1, alu2_in2;
  logic           busy2;

  alu_share_ctrl #(.NUM_REQ(N), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .alu_opcode(alu_opcode), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_result(alu_result), .busy(busy));

  alu_share_ctrl #(.NUM_REQ(N), .ALU_LAT(LAT2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req2_valid), .req_ready(req2_ready),
    .req_opcode(req2_opcode), .req_in1(req2_in1), .req_in2(req2_in2),
    .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready), .rsp_id(rsp2_id),
    .rsp_result(rsp2_result), .alu_opcode(alu2_opcode), .alu_in1(alu2_in1),
    .alu_in2(alu2_in2), .alu_result(alu2_result), .busy(busy2));

  // ALU behaviour: add, sub, and, or, xor, shl1, shr1, rotate-left by in2 mod 5.
  function automatic int alu_ref(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
    int x, y, r, s;
    x = int'(a);
    y = int'(b);
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x * 2;
      3'd6: r = x / 2;
      default: begin
        s = y % 5;
        r = ((x << s) | (x >> (5 - s))) & 31;
      end
    endcase
    return r & 63;
  endfunction

  logic [5:0] p1, p2a, p2b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0; p2a <= '0; p2b <= '0;
    end else begin
      p1  <= 6'(alu_ref(alu_opcode, alu_in1, alu_in2));
      p2a <= 6'(alu_ref(alu2_opcode, alu2_in1, alu2_in2));
      p2b <= p2a;
    end
  end
  assign alu_result  = p1;
  assign alu2_result = p2b;

  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int res; int cap; } exp_t;
  exp_t sbq[$];
  bit tb_en = 1'b0;

  // Reference model: one op in flight, round-robin pointer, fixed latency.
  bit          m_busy = 1'b0;
  int          m_ptr = 0, m_hs = 0, m_cap = 0;
  logic [12:0] m_cur = '0, m_pend = '0;
  always @(negedge clk) begin
    int w, exp_rdy;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_hs = 0; m_cap = 0; m_cur = '0; m_pend = '0;
    end else if (tb_en) begin
      if (cyc >= m_hs) m_cur = m_pend;
      chk("alu_ops", int'({alu_opcode, alu_in1, alu_in2}), int'(m_cur));
      chk("busy", int'(busy), int'(m_busy && cyc >= m_hs));
      if (!m_busy) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        exp_rdy = (w >= 0) ? (1 << w) : 0;
        chk("req_ready", int'(req_ready), exp_rdy);
        if (w >= 0) begin
          m_hs   = cyc + 1;
          m_cap  = cyc + 2 + LAT;
          m_pend = {req_opcode[3*w +: 3], req_in1[5*w +: 5], req_in2[5*w +: 5]};
          sbq.push_back('{id: w,
                          res: alu_ref(req_opcode[3*w +: 3], req_in1[5*w +: 5], req_in2[5*w +: 5]),
                          cap: m_cap});
          m_ptr  = (w + 1) % N;
          m_busy = 1'b1;
        end
      end else begin
        chk("req_ready_busy", int'(req_ready), 0);
        if (cyc >= m_cap && rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // Monitor: compares every presented response to the scoreboard head.
  bit mon_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      mon_prev = 1'b0;
    end else if (tb_en) begin
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", int'(rsp_valid), 0);
        end else begin
          if (!mon_prev) chk("rsp_latency", cyc, sbq[0].cap);
          chk("rsp_id", int'(rsp_id), sbq[0].id);
          chk("rsp_result", int'(rsp_result), sbq[0].res);
          if (rsp_ready) void'(sbq.pop_front());
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].cap) begin
        chk("rsp_missing", int'(rsp_valid), 1);
        void'(sbq.pop_front());
      end
      mon_prev = rsp_valid && !rsp_ready;
    end
  end

  task automatic set_req(input int id, input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
    req_opcode[3*id +: 3] = op;
    req_in1[5*id +: 5]    = a;
    req_in2[5*id +: 5]    = b;
    req_valid[id]         = 1'b1;
  endtask

  task automatic wait_grant(input int id);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    chk("grant_timeout", int'(got), 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    bit got;
    int e2;
    rst = 1'b1;
    req_valid = '1; req_opcode = '0; req_in1 = '0; req_in2 = '0; rsp_ready = 1'b0;
    req2_valid = '0; req2_opcode = '0; req2_in1 = '0; req2_in2 = '0; rsp2_ready = 1'b1;
    #12;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_result", int'(rsp_result), 0);
    chk("rst_alu_ops", int'({alu_opcode, alu_in1, alu_in2}), 0);
    chk("rst_busy", int'(busy), 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tb_en = 1'b1;

    // Directed operations: add 5+3, subtract wrap, rotate.
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    set_req(0, 3'd0, 5'd5, 5'd3);  wait_grant(0);
    set_req(2, 3'd1, 5'd3, 5'd5);  wait_grant(2);
    set_req(1, 3'd7, 5'b10001, 5'd1); wait_grant(1);
    repeat (6) @(posedge clk); #1;

    // All requesters held high: grant order follows the pointer.
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 5'(3*i + 1), 5'(i + 7));
    repeat (20) @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk); #1;

    // Backpressure on the response channel.
    rsp_ready = 1'b0;
    set_req(1, 3'd4, 5'd9, 5'd22); wait_grant(1);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_rsp_timeout", int'(got), 1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    set_req(3, 3'd5, 5'd21, 5'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grant(3);
    repeat (6) @(posedge clk); #1;

    // Randomized traffic with withdrawals and random backpressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !g[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 3'($urandom), 5'($urandom), 5'($urandom));
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (8) @(posedge clk); #1;

    // Reset one cycle after a handshake: operation abandoned, pointer back to 0.
    set_req(2, 3'd0, 5'd11, 5'd12); wait_grant(2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_alu_ops", int'({alu_opcode, alu_in1, alu_in2}), 0);
    set_req(1, 3'd2, 5'd30, 5'd15);
    set_req(3, 3'd3, 5'd16, 5'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    wait_grant(1);
    wait_grant(3);
    repeat (8) @(posedge clk); #1;

    // ALU_LAT = 2: capture lands on handshake edge + 3.
    req2_opcode[6 +: 3] = 3'($urandom);
    req2_in1[10 +: 5]   = 5'($urandom);
    req2_in2[10 +: 5]   = 5'($urandom);
    req2_valid[2]       = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req2_ready[2]) got = 1'b1;
    end
    chk("lat2_grant_timeout", int'(got), 1);
    @(posedge clk); #1;
    req2_valid = '0;
    e2 = alu_ref(req2_opcode[6 +: 3], req2_in1[10 +: 5], req2_in2[10 +: 5]);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("lat2_early_valid", int'(rsp2_valid), 0);
    end
    @(negedge clk);
    chk("lat2_capture_valid", int'(rsp2_valid), 1);
    chk("lat2_rsp_id", int'(rsp2_id), 2);
    chk("lat2_rsp_result", int'(rsp2_result), e2);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares the single 5-bit ALU datapath (3-bit opcode, 5-bit in1/in2, 6-bit registered result) among NUM_REQ requesters.
- Accepts one operation at a time through a valid/ready handshake and drives the ALU operand/opcode inputs.
- Waits out the ALU pipeline latency, captures the result, and returns it through a response valid/ready channel tagged with the requester id.
- Sits between the requester logic and the ALU instance; the ALU's own clk/rst are wired in parallel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LAT, 1, ALU clock cycles from operands stable at an edge to result visible after the next edge (1 for the current ALU).
- ID_W, $clog2(NUM_REQ), width of rsp_id.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_opcode  in  3*NUM_REQ  packed opcodes; requester i at [3i+2:3i]
- req_in1  in  5*NUM_REQ  packed operand A; requester i at [5i+4:5i]
- req_in2  in  5*NUM_REQ  packed operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester index owning rsp_result
- rsp_result  out  6  captured ALU result
- alu_opcode  out  3  to ALU opcode
- alu_in1  out  5  to ALU in1
- alu_in2  out  5  to ALU in2
- alu_result  in  6  from ALU result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, wait counter=0. All of the following are 0: alu_opcode, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_result, busy. req_ready=0 while rst=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0. No req_valid set means req_ready=0.
  - At the handshake edge: register the winner's opcode/in1/in2 onto alu_*, load cnt=ALU_LAT, set rr_ptr=(winner+1) mod NUM_REQ, latch winner id, go to EXEC.
- EXEC:
  - req_ready=0.
  - Each edge: if cnt==0, capture alu_result into rsp_result, rsp_id=latched id, rsp_valid=1, go to RESP; else cnt--.
  - With ALU_LAT=1, the capture edge is handshake edge +2.
- RESP:
  - rsp_valid, rsp_id and rsp_result hold stable until rsp_valid&rsp_ready at an edge.
  - On that edge: rsp_valid=0, go to IDLE. rsp_result and rsp_id keep their last value.
  - req_ready=0 throughout RESP; no new acceptance until back in IDLE.
- alu_* hold the last issued operands in EXEC, RESP and IDLE. They change only on a handshake edge.
- Requester side: req_valid must stay high with stable payload until req_ready. Deasserting req_valid before grant simply withdraws the request; no error, and rr_ptr is unchanged.
- Throughput: one operation per 4 cycles minimum (ALU_LAT=1, rsp_ready held high). Handshake at E0, capture at E2, response accepted at E3, next handshake at E4.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.
- Result width: rsp_result is the ALU's 6-bit value unmodified; the controller performs no arithmetic.
- Reset mid-operation (EXEC or RESP): the operation is abandoned, rsp_valid drops immediately, and there is no response after release. rr_ptr returns to 0.
- Simultaneous events:
  - rsp_ready high on the capture edge has no effect; acceptance requires rsp_valid already high.
  - req_valid changes during EXEC/RESP are ignored.

Test Plan:
- Single request: req 0, opcode 000, in1=5, in2=3 → req_ready[0] for 1 cycle; rsp_valid 2 edges after the handshake; rsp_result=8, rsp_id=0; busy high for 3 cycles.
- Subtract wrap: opcode 001, in1=3, in2=5 on req 2 → rsp_result=6'h3E, rsp_id=2.
- Rotate: opcode 111, in1=5'b10001, in2=1 → rsp_result=3.
- Round-robin: all 4 req_valid held high with distinct ADD operands, rsp_ready=1 → grant order 0,1,2,3,0, each 4 cycles apart; each result matches the owning id.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid → rsp_valid/rsp_result/rsp_id stable, all req_ready=0, alu_* unchanged. On rsp_ready=1, IDLE on the next edge and a pending req is granted the cycle after.
- Reset mid-EXEC: assert rst asynchronously one cycle after the handshake → rsp_valid=0, busy=0, alu_*=0 immediately. After release, no response appears and a pending req 3 is granted only after req 0..2 are checked (rr_ptr=0). Repeat with ALU_LAT=2 → capture at handshake edge +3.
